// File: rtl/reg_write_ctrl.sv
// Register-file write-side controller: queues mem/alu results in program order, drains one
// write per cycle onto the single write port, and forwards the youngest pending value.
module reg_write_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [2:0]  mem_dst,
    input  logic [15:0] mem_data,
    input  logic        alu_valid,
    input  logic [2:0]  alu_dst,
    input  logic [15:0] alu_data,
    output logic        stall_out,
    output logic [2:0]  write_addr,
    output logic [15:0] write_data,
    output logic        reg_write,
    input  logic [2:0]  fwd_addr,
    output logic        fwd_hit,
    output logic [15:0] fwd_data
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [2:0]      dst_q  [DEPTH];
    logic [15:0]     data_q [DEPTH];

    logic            push_mem, push_alu, pop;
    logic [PtrW-1:0] alu_slot;
    logic [CntW-1:0] n_push;

    // Threshold leaves room for a worst-case dual push next cycle.
    assign stall_out = (count_q > CntW'(DEPTH - 2));

    always_comb begin
        push_mem = mem_valid && !stall_out;
        push_alu = alu_valid && !stall_out;
        pop      = (count_q != '0);
        alu_slot = push_mem ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
        n_push   = CntW'(push_mem) + CntW'(push_alu);
        wr_ptr_d = wr_ptr_q + PtrW'(n_push);
        rd_ptr_d = pop ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
        count_d  = count_q + n_push - CntW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_mem) begin
            dst_q[wr_ptr_q]  <= mem_dst;
            data_q[wr_ptr_q] <= mem_data;
        end
        if (push_alu) begin
            dst_q[alu_slot]  <= alu_dst;
            data_q[alu_slot] <= alu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else if (pop) begin
            reg_write  <= 1'b1;
            write_addr <= dst_q[rd_ptr_q];
            write_data <= data_q[rd_ptr_q];
        end else begin
            reg_write  <= 1'b0;
        end
    end

    // Scan oldest to youngest so later matches override earlier ones.
    always_comb begin
        logic [PtrW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (reg_write && (write_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = write_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if ((CntW'(i) < count_q) && (dst_q[idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Self-checking bench for reg_write_ctrl: directed scenarios plus random traffic against
// a queue-based reference model.
module tb_reg_write_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic [2:0]  mem_dst, alu_dst, fwd_addr;
    logic [15:0] mem_data, alu_data;
    logic        stall_out, reg_write, fwd_hit;
    logic [2:0]  write_addr;
    logic [15:0] write_data, fwd_data;

    always #5 clk = ~clk;

    reg_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_dst    (mem_dst),
        .mem_data   (mem_data),
        .alu_valid  (alu_valid),
        .alu_dst    (alu_dst),
        .alu_data   (alu_data),
        .stall_out  (stall_out),
        .write_addr (write_addr),
        .write_data (write_data),
        .reg_write  (reg_write),
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    typedef struct {
        logic [2:0]  dst;
        logic [15:0] data;
    } ent_t;

    // Reference model: pending writes in program order plus the write-port register.
    ent_t        mq[$];
    logic        m_rw;
    logic [2:0]  m_addr;
    logic [15:0] m_data;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_fwd(input logic [2:0] fa, output logic hit,
                                      output logic [15:0] data);
        hit  = 1'b0;
        data = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].dst == fa) begin
                hit  = 1'b1;
                data = mq[i].data;
                return;
            end
        end
        if (m_rw && m_addr == fa) begin
            hit  = 1'b1;
            data = m_data;
        end
    endfunction

    task automatic check_fwd(input string tag);
        logic        h;
        logic [15:0] d;
        model_fwd(fwd_addr, h, d);
        check({tag, "_fwd_hit"}, 16'(fwd_hit), 16'(h));
        check({tag, "_fwd_data"}, fwd_data, d);
    endtask

    // One clock: drive inputs, check pre-edge outputs, advance model, check post-edge.
    task automatic step(input logic mv, input logic [2:0] md, input logic [15:0] mdat,
                        input logic av, input logic [2:0] ad, input logic [15:0] adat,
                        input logic [2:0] fa, output logic acc);
        logic m_stall;
        ent_t e;
        mem_valid = mv; mem_dst = md; mem_data = mdat;
        alu_valid = av; alu_dst = ad; alu_data = adat;
        fwd_addr  = fa;
        #1;
        m_stall = (mq.size() > DEPTH - 2);
        check("stall", 16'(stall_out), 16'(m_stall));
        check_fwd("pre");
        @(posedge clk);
        if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_rw   = 1'b1;
            m_addr = e.dst;
            m_data = e.data;
        end else begin
            m_rw = 1'b0;
        end
        if (!m_stall) begin
            if (mv) mq.push_back('{dst: md, data: mdat});
            if (av) mq.push_back('{dst: ad, data: adat});
        end
        acc = !m_stall;
        #1;
        check("reg_write", 16'(reg_write), 16'(m_rw));
        check("write_addr", 16'(write_addr), 16'(m_addr));
        check("write_data", write_data, m_data);
        check_fwd("post");
    endtask

    task automatic idle(input logic [2:0] fa);
        logic acc;
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, fa, acc);
    endtask

    initial begin
        logic acc;
        int   k;
        mem_valid = 0; alu_valid = 0; mem_dst = 0; alu_dst = 0;
        mem_data = 0; alu_data = 0; fwd_addr = 0;
        m_rw = 0; m_addr = 0; m_data = 0;
        reset = 1'b1;
        #1;
        check("rst_reg_write", 16'(reg_write), 16'h0);
        check("rst_stall", 16'(stall_out), 16'h0);
        check("rst_write_data", write_data, 16'h0);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;

        // Single push: write one cycle after entering the queue, forwardable throughout.
        step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 3'd3, acc);
        check("single_fwd_q", 16'(fwd_hit), 16'h1);
        idle(3'd3);
        check("single_rw", 16'(reg_write), 16'h1);
        check("single_addr", 16'(write_addr), 16'h3);
        check("single_data", write_data, 16'h1234);
        check("single_fwd_out", 16'(fwd_hit), 16'h1);
        idle(3'd3);
        check("single_fwd_gone", 16'(fwd_hit), 16'h0);

        // Dual push to the same destination: alu value is youngest.
        step(1'b1, 3'd2, 16'h00AA, 1'b1, 3'd2, 16'h00BB, 3'd2, acc);
        check("dual_fwd_both", fwd_data, 16'h00BB);
        idle(3'd2);
        check("dual_first", write_data, 16'h00AA);
        check("dual_fwd_mid", fwd_data, 16'h00BB);
        idle(3'd2);
        check("dual_second", write_data, 16'h00BB);
        check("dual_fwd_last", fwd_data, 16'h00BB);
        idle(3'd2);

        // Back-to-back dual pushes; upstream holds its pair while stalled.
        k = 0;
        for (int it = 0; it < 20 && k < 8; it++) begin
            step(1'b1, 3'(k), 16'h0200 + 16'(k), 1'b1, 3'(k + 1), 16'h0200 + 16'(k + 1),
                 3'(k), acc);
            if (it == 1) check("b2b_stall", 16'(stall_out), 16'h1);
            if (acc) k += 2;
        end
        check("b2b_all_accepted", 16'(k), 16'd8);
        for (int i = 0; i < 8; i++) idle(3'($urandom_range(0, 7)));

        // Wrap-around with single pushes.
        for (int i = 0; i < 10; i++)
            step(1'b1, 3'(i % 8), 16'h0100 + 16'(i), 1'b0, 3'd0, 16'h0, 3'(i % 8), acc);
        idle(3'd1);
        idle(3'd1);
        check("wrap_last_data", write_data, 16'h0109);

        // Idle: nothing forwardable, port register holds.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            for (int a = 0; a < 8; a++) begin
                fwd_addr = 3'(a);
                #1;
                check("idle_fwd_hit", 16'(fwd_hit), 16'h0);
            end
            check("idle_rw", 16'(reg_write), 16'h0);
            check("idle_addr", 16'(write_addr), 16'h1);
            check("idle_data", write_data, 16'h0109);
        end
        m_rw = 1'b0;

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 3'($urandom_range(0, 7)), acc);
        for (int i = 0; i < 6; i++) idle(3'($urandom_range(0, 7)));

        // Asynchronous reset with three entries queued.
        step(1'b1, 3'd4, 16'h0444, 1'b1, 3'd5, 16'h0555, 3'd5, acc);
        step(1'b1, 3'd6, 16'h0666, 1'b1, 3'd7, 16'h0777, 3'd7, acc);
        check("pre_rst_stall", 16'(stall_out), 16'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rw", 16'(reg_write), 16'h0);
        check("mid_rst_stall", 16'(stall_out), 16'h0);
        check("mid_rst_fwd", 16'(fwd_hit), 16'h0);
        mq.delete();
        m_rw = 1'b0; m_addr = '0; m_data = '0;
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(3'($urandom_range(4, 7)));
            check("post_rst_no_write", 16'(reg_write), 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
